// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared types and sizing for the CTR coordinate-fetch path
package ctr_pkg;

    // Arbitration policy selected by CCU at configuration time.
    typedef enum logic {
        ARB_RR  = 1'b0,   // round-robin starting at the rotating pointer
        ARB_FIX = 1'b1    // fixed priority, engine 0 highest
    } arb_mode_e;

    localparam int CTR_NUM_ENG   = 4;
    localparam int CTR_TAG_DEPTH = 4;

    // Index width that never collapses to zero bits for single-entry cases.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ENG_ID_WIDTH  = clog2_min1(CTR_NUM_ENG);
    localparam int TAG_CNT_WIDTH = $clog2(CTR_TAG_DEPTH) + 1;

endpackage

// File: rtl/ctr_tag_fifo.sv
// rtl/ctr_tag_fifo.sv - in-order tag FIFO recording which engine owns each outstanding read
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_tag  enqueue the granted engine id (ignored while full)
//   pop             dequeue the head tag (ignored while empty)
//   head_tag        engine id owning the oldest outstanding read
//   full, empty     registered status flags
module ctr_tag_fifo
    import ctr_pkg::*;
#(
    parameter int DEPTH = CTR_TAG_DEPTH,
    parameter int TAG_W = ENG_ID_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head_tag,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full_q;
    assign do_pop   = pop & ~empty_q;
    assign head_tag = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        // Flags are derived from the next count so they are plain flops.
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/crd_fetch_arb.sv
// rtl/crd_fetch_arb.sv - arbitrates point engines onto the single GLB coordinate read port
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   CCUCTR_CfgVld/CTRCCU_CfgRdy config handshake; ready only while no read is outstanding
//   CCUCTR_CfgEn, CfgArbMod     engine enable mask, 0 = round-robin / 1 = fixed priority
//   ENGCTR_CrdAddr/Vld, CTRENG_CrdAddrRdy   per-engine address requests
//   CTRGLB_CrdAddr/Vld, GLBCTR_CrdAddrRdy   arbitrated address to GLB
//   GLBCTR_Crd/Vld, CTRGLB_CrdRdy           returned coordinate word from GLB
//   CTRENG_Crd/Vld, ENGCTR_CrdRdy           word broadcast, one-hot valid to owning engine
//   CTRCCU_Err                  sticky flag: GLB returned a word with no outstanding read
module crd_fetch_arb
    import ctr_pkg::*;
#(
    parameter int NUM_ENG    = CTR_NUM_ENG,
    parameter int IDX_WIDTH  = 10,
    parameter int SRAM_WIDTH = 256,
    parameter int TAG_DEPTH  = CTR_TAG_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         CCUCTR_CfgVld,
    output logic                         CTRCCU_CfgRdy,
    input  logic [NUM_ENG-1:0]           CCUCTR_CfgEn,
    input  logic                         CCUCTR_CfgArbMod,
    input  logic [NUM_ENG*IDX_WIDTH-1:0] ENGCTR_CrdAddr,
    input  logic [NUM_ENG-1:0]           ENGCTR_CrdAddrVld,
    output logic [NUM_ENG-1:0]           CTRENG_CrdAddrRdy,
    output logic [IDX_WIDTH-1:0]         CTRGLB_CrdAddr,
    output logic                         CTRGLB_CrdAddrVld,
    input  logic                         GLBCTR_CrdAddrRdy,
    input  logic [SRAM_WIDTH-1:0]        GLBCTR_Crd,
    input  logic                         GLBCTR_CrdVld,
    output logic                         CTRGLB_CrdRdy,
    output logic [SRAM_WIDTH-1:0]        CTRENG_Crd,
    output logic [NUM_ENG-1:0]           CTRENG_CrdVld,
    input  logic [NUM_ENG-1:0]           ENGCTR_CrdRdy,
    output logic                         CTRCCU_Err
);

    localparam int EW = clog2_min1(NUM_ENG);

    logic [NUM_ENG-1:0] en_mask_q, en_mask_d;
    arb_mode_e          mode_q, mode_d;
    logic [EW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               lock_q, lock_d;
    logic [EW-1:0]      lock_id_q, lock_id_d;
    logic               err_q, err_d;

    logic [NUM_ENG-1:0] req;
    logic [EW-1:0]      gnt;
    logic [EW-1:0]      gnt_rr;
    logic [EW-1:0]      gnt_fix;
    logic               rr_found;
    logic               fix_found;
    int                 rr_idx;
    logic               addr_acc;
    logic               cfg_acc;
    logic               tag_full;
    logic               tag_empty;
    logic [EW-1:0]      head;
    logic               ret_pop;

    assign req      = ENGCTR_CrdAddrVld & en_mask_q;
    assign cfg_acc  = CCUCTR_CfgVld & CTRCCU_CfgRdy;
    assign CTRCCU_CfgRdy = tag_empty;
    assign CTRCCU_Err    = err_q;

    // Grant selection. A locked grant overrides both policies so the
    // address presented to a stalled GLB cannot change until accepted.
    always_comb begin
        gnt_rr   = rr_ptr_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NUM_ENG; k++) begin
            rr_idx = (int'(rr_ptr_q) + k) % NUM_ENG;
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                gnt_rr   = EW'(rr_idx);
            end
        end

        gnt_fix   = '0;
        fix_found = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (!fix_found && req[k]) begin
                fix_found = 1'b1;
                gnt_fix   = EW'(k);
            end
        end

        if (lock_q) begin
            gnt = lock_id_q;
        end else if (mode_q == ARB_FIX) begin
            gnt = gnt_fix;
        end else begin
            gnt = gnt_rr;
        end
    end

    // Address path: readiness uses only the registered full flag, so a pop
    // in the same cycle never opens a slot combinationally.
    assign CTRGLB_CrdAddrVld = (|req) & ~tag_full;
    assign CTRGLB_CrdAddr    = ENGCTR_CrdAddr[int'(gnt)*IDX_WIDTH +: IDX_WIDTH];
    assign addr_acc          = CTRGLB_CrdAddrVld & GLBCTR_CrdAddrRdy;

    always_comb begin
        CTRENG_CrdAddrRdy = '0;
        if (addr_acc) begin
            CTRENG_CrdAddrRdy[gnt] = 1'b1;
        end
    end

    // Return path: the head tag names the engine that owns the next word.
    assign CTRENG_Crd    = GLBCTR_Crd;
    assign CTRGLB_CrdRdy = ~tag_empty & ENGCTR_CrdRdy[head];
    assign ret_pop       = GLBCTR_CrdVld & CTRGLB_CrdRdy;

    always_comb begin
        CTRENG_CrdVld = '0;
        if (GLBCTR_CrdVld && !tag_empty) begin
            CTRENG_CrdVld[head] = 1'b1;
        end
    end

    always_comb begin
        en_mask_d = en_mask_q;
        mode_d    = mode_q;
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q;

        if (addr_acc) begin
            rr_ptr_d = (gnt == EW'(NUM_ENG - 1)) ? '0 : gnt + 1'b1;
            lock_d   = 1'b0;
        end else if (CTRGLB_CrdAddrVld) begin
            lock_d    = 1'b1;
            lock_id_d = gnt;
        end

        // Config only lands while idle; it restarts the rotation and clears Err.
        if (cfg_acc) begin
            en_mask_d = CCUCTR_CfgEn;
            mode_d    = arb_mode_e'(CCUCTR_CfgArbMod);
            rr_ptr_d  = '0;
            err_d     = 1'b0;
        end

        // A new spurious word wins over a same-cycle config clear.
        if (GLBCTR_CrdVld && tag_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_mask_q <= '0;
            mode_q    <= ARB_RR;
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            en_mask_q <= en_mask_d;
            mode_q    <= mode_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    ctr_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .TAG_W (EW)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (addr_acc),
        .push_tag (gnt),
        .pop      (ret_pop),
        .head_tag (head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

endmodule

// File: tb/tb_crd_fetch_arb.sv
// tb/tb_crd_fetch_arb.sv - scoreboard bench for crd_fetch_arb
module tb_crd_fetch_arb;

    localparam int NE = 4;
    localparam int IW = 10;
    localparam int SW = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             CCUCTR_CfgVld;
    logic             CTRCCU_CfgRdy;
    logic [NE-1:0]    CCUCTR_CfgEn;
    logic             CCUCTR_CfgArbMod;
    logic [NE*IW-1:0] ENGCTR_CrdAddr;
    logic [NE-1:0]    ENGCTR_CrdAddrVld;
    logic [NE-1:0]    CTRENG_CrdAddrRdy;
    logic [IW-1:0]    CTRGLB_CrdAddr;
    logic             CTRGLB_CrdAddrVld;
    logic             GLBCTR_CrdAddrRdy;
    logic [SW-1:0]    GLBCTR_Crd;
    logic             GLBCTR_CrdVld;
    logic             CTRGLB_CrdRdy;
    logic [SW-1:0]    CTRENG_Crd;
    logic [NE-1:0]    CTRENG_CrdVld;
    logic [NE-1:0]    ENGCTR_CrdRdy;
    logic             CTRCCU_Err;

    always #5 clk = ~clk;

    crd_fetch_arb #(
        .NUM_ENG    (NE),
        .IDX_WIDTH  (IW),
        .SRAM_WIDTH (SW),
        .TAG_DEPTH  (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .CCUCTR_CfgVld     (CCUCTR_CfgVld),
        .CTRCCU_CfgRdy     (CTRCCU_CfgRdy),
        .CCUCTR_CfgEn      (CCUCTR_CfgEn),
        .CCUCTR_CfgArbMod  (CCUCTR_CfgArbMod),
        .ENGCTR_CrdAddr    (ENGCTR_CrdAddr),
        .ENGCTR_CrdAddrVld (ENGCTR_CrdAddrVld),
        .CTRENG_CrdAddrRdy (CTRENG_CrdAddrRdy),
        .CTRGLB_CrdAddr    (CTRGLB_CrdAddr),
        .CTRGLB_CrdAddrVld (CTRGLB_CrdAddrVld),
        .GLBCTR_CrdAddrRdy (GLBCTR_CrdAddrRdy),
        .GLBCTR_Crd        (GLBCTR_Crd),
        .GLBCTR_CrdVld     (GLBCTR_CrdVld),
        .CTRGLB_CrdRdy     (CTRGLB_CrdRdy),
        .CTRENG_Crd        (CTRENG_Crd),
        .CTRENG_CrdVld     (CTRENG_CrdVld),
        .ENGCTR_CrdRdy     (ENGCTR_CrdRdy),
        .CTRCCU_Err        (CTRCCU_Err)
    );

    typedef struct packed {
        logic [1:0]    eng;
        logic [IW-1:0] addr;
    } exp_t;

    exp_t          exp_q[$];
    logic [IW-1:0] glb_q[$];
    int            glb_t[$];
    int            gnt_log[$];

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;

    int            eng_left[NE];
    int            eng_seq[NE];
    logic [NE-1:0] eng_drdy;
    logic          glb_ardy;
    int            ret_lat;
    int            ret_budget;
    bit            spur;
    logic          cfg_vld_r;
    logic [NE-1:0] cfg_en_r;
    logic          cfg_mode_r;

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] eng_addr(input int i);
        return IW'((i << 8) | (eng_seq[i] & 8'hff));
    endfunction

    function automatic logic [SW-1:0] data_of(input logic [IW-1:0] a);
        logic [31:0] w;
        w = 32'hA5C3_0000 ^ {22'h0, a} ^ ({22'h0, a} << 13);
        return {8{w}};
    endfunction

    // Drive this cycle's inputs from the engine/GLB models, then let outputs settle.
    task automatic settle();
        CCUCTR_CfgVld    = cfg_vld_r;
        CCUCTR_CfgEn     = cfg_en_r;
        CCUCTR_CfgArbMod = cfg_mode_r;
        for (int i = 0; i < NE; i++) begin
            ENGCTR_CrdAddrVld[i]        = (eng_left[i] > 0);
            ENGCTR_CrdAddr[i*IW +: IW]  = eng_addr(i);
        end
        ENGCTR_CrdRdy     = eng_drdy;
        GLBCTR_CrdAddrRdy = glb_ardy;
        if (glb_q.size() > 0 && glb_t[0] <= cyc && ret_budget != 0) begin
            GLBCTR_CrdVld = 1'b1;
            GLBCTR_Crd    = data_of(glb_q[0]);
        end else if (spur) begin
            GLBCTR_CrdVld = 1'b1;
            GLBCTR_Crd    = '1;
        end else begin
            GLBCTR_CrdVld = 1'b0;
            GLBCTR_Crd    = '0;
        end
        #1;
    endtask

    // Record handshakes happening at the coming edge, score returns, advance a cycle.
    task automatic finish_cycle();
        int   g;
        exp_t e;
        if (CTRGLB_CrdAddrVld && GLBCTR_CrdAddrRdy) begin
            check("addr_rdy_onehot", SW'($countones(CTRENG_CrdAddrRdy)), SW'(1));
            g = 0;
            for (int i = 0; i < NE; i++) if (CTRENG_CrdAddrRdy[i]) g = i;
            check("glb_addr", SW'(CTRGLB_CrdAddr), SW'(eng_addr(g)));
            e.eng  = 2'(g);
            e.addr = eng_addr(g);
            exp_q.push_back(e);
            gnt_log.push_back(g);
            glb_q.push_back(e.addr);
            glb_t.push_back(cyc + ret_lat);
            eng_left[g]--;
            eng_seq[g]++;
        end
        if (GLBCTR_CrdVld && CTRGLB_CrdRdy) begin
            if (exp_q.size() == 0) begin
                check("ret_unexpected", SW'(1), SW'(0));
            end else begin
                e = exp_q.pop_front();
                check("ret_vld", SW'(CTRENG_CrdVld), SW'(4'b0001 << e.eng));
                check("ret_data", CTRENG_Crd, data_of(e.addr));
            end
            if (glb_q.size() > 0) begin
                void'(glb_q.pop_front());
                void'(glb_t.pop_front());
                if (ret_budget > 0) ret_budget--;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        settle();
        finish_cycle();
    endtask

    task automatic drain(input int max_cyc);
        int  k;
        bit  busy;
        k = 0;
        busy = 1'b1;
        while (busy && k < max_cyc) begin
            busy = (exp_q.size() > 0);
            for (int i = 0; i < NE; i++) if (eng_left[i] > 0 && cfg_en_r[i]) busy = 1'b1;
            if (busy) step();
            k++;
        end
        if (busy) check("drain_timeout", SW'(0), SW'(1));
        step();
    endtask

    task automatic do_cfg(input logic [NE-1:0] en, input logic mode);
        cfg_vld_r  = 1'b1;
        cfg_en_r   = en;
        cfg_mode_r = mode;
        settle();
        check("cfg_rdy", SW'(CTRCCU_CfgRdy), SW'(1));
        finish_cycle();
        cfg_vld_r = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        eng_drdy   = '1;
        glb_ardy   = 1'b1;
        ret_lat    = 1;
        ret_budget = -1;
        spur       = 1'b0;
        cfg_vld_r  = 1'b0;
        cfg_en_r   = '0;
        cfg_mode_r = 1'b0;
        for (int i = 0; i < NE; i++) begin
            eng_left[i] = 1;
            eng_seq[i]  = 0;
        end
        settle();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state: engines request but none is enabled yet.
        settle();
        check("rst_addr_vld", SW'(CTRGLB_CrdAddrVld), SW'(0));
        check("rst_addr_rdy", SW'(CTRENG_CrdAddrRdy), SW'(0));
        check("rst_crd_vld",  SW'(CTRENG_CrdVld),     SW'(0));
        check("rst_crd_rdy",  SW'(CTRGLB_CrdRdy),     SW'(0));
        check("rst_cfg_rdy",  SW'(CTRCCU_CfgRdy),     SW'(1));
        check("rst_err",      SW'(CTRCCU_Err),        SW'(0));
        finish_cycle();
        for (int i = 0; i < NE; i++) eng_left[i] = 0;

        // Round-robin between engines 0 and 1; engine 2 requests but is disabled.
        do_cfg(4'b0011, 1'b0);
        gnt_log.delete();
        ret_lat = 2;
        eng_left[0] = 4;
        eng_left[1] = 4;
        eng_left[2] = 2;
        drain(60);
        check("rr_count", SW'(gnt_log.size()), SW'(8));
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            check("rr_grant", SW'(gnt_log[i]), SW'(i % 2));
        check("rr_disabled_untouched", SW'(eng_left[2]), SW'(2));
        eng_left[2] = 0;

        // Fixed priority: engine 0 wins every cycle while it has requests.
        do_cfg(4'b1111, 1'b1);
        gnt_log.delete();
        ret_lat = 1;
        for (int i = 0; i < NE; i++) eng_left[i] = 3;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("fix_rdy", SW'(CTRENG_CrdAddrRdy), SW'(4'b0001));
            finish_cycle();
        end
        drain(60);
        check("fix_count", SW'(gnt_log.size()), SW'(12));
        for (int i = 0; i < 12 && i < gnt_log.size(); i++)
            check("fix_grant", SW'(gnt_log[i]), SW'(i / 3));

        // Lock: engine 2 stalled by GLB while engine 1 also requests.
        do_cfg(4'b1111, 1'b0);
        gnt_log.delete();
        glb_ardy = 1'b0;
        eng_left[2] = 1;
        settle();
        check("lock_vld0",  SW'(CTRGLB_CrdAddrVld), SW'(1));
        check("lock_addr0", SW'(CTRGLB_CrdAddr),    SW'(eng_addr(2)));
        check("lock_rdy0",  SW'(CTRENG_CrdAddrRdy), SW'(0));
        finish_cycle();
        eng_left[1] = 1;
        for (int c = 0; c < 2; c++) begin
            settle();
            check("lock_vld",  SW'(CTRGLB_CrdAddrVld), SW'(1));
            check("lock_addr", SW'(CTRGLB_CrdAddr),    SW'(eng_addr(2)));
            finish_cycle();
        end
        glb_ardy = 1'b1;
        settle();
        check("lock_accept", SW'(CTRENG_CrdAddrRdy), SW'(4'b0100));
        finish_cycle();
        drain(30);
        check("lock_order_n", SW'(gnt_log.size()), SW'(2));
        if (gnt_log.size() >= 2) begin
            check("lock_first", SW'(gnt_log[0]), SW'(2));
            check("lock_next",  SW'(gnt_log[1]), SW'(1));
        end

        // FIFO full: four accepts, then blocked even in the popping cycle.
        do_cfg(4'b0001, 1'b0);
        gnt_log.delete();
        ret_budget = 0;
        eng_left[0] = 6;
        repeat (4) step();
        settle();
        check("full_addr_vld", SW'(CTRGLB_CrdAddrVld), SW'(0));
        check("full_cfg_rdy",  SW'(CTRCCU_CfgRdy),     SW'(0));
        finish_cycle();
        ret_budget = 1;
        settle();
        check("full_pop_rdy",      SW'(CTRGLB_CrdRdy),     SW'(1));
        check("full_pop_addr_vld", SW'(CTRGLB_CrdAddrVld), SW'(0));
        finish_cycle();
        settle();
        check("full_reopen", SW'(CTRGLB_CrdAddrVld), SW'(1));
        finish_cycle();
        ret_budget = -1;
        drain(40);
        check("full_count", SW'(gnt_log.size()), SW'(6));

        // Engine stall: head owned by engine 3, engine 0's word queued behind it.
        do_cfg(4'b1111, 1'b0);
        gnt_log.delete();
        eng_drdy = 4'b0111;
        eng_left[3] = 1;
        step();
        eng_left[0] = 1;
        step();
        for (int c = 0; c < 3; c++) begin
            settle();
            check("stall_crd_rdy", SW'(CTRGLB_CrdRdy), SW'(0));
            check("stall_crd_vld", SW'(CTRENG_CrdVld), SW'(4'b1000));
            finish_cycle();
        end
        eng_drdy = '1;
        drain(30);
        if (gnt_log.size() >= 2) begin
            check("stall_g0", SW'(gnt_log[0]), SW'(3));
            check("stall_g1", SW'(gnt_log[1]), SW'(0));
        end else begin
            check("stall_count", SW'(gnt_log.size()), SW'(2));
        end

        // Spurious return data while idle sets a sticky error.
        spur = 1'b1;
        settle();
        check("spur_rdy", SW'(CTRGLB_CrdRdy), SW'(0));
        check("spur_vld", SW'(CTRENG_CrdVld), SW'(0));
        finish_cycle();
        spur = 1'b0;
        settle();
        check("spur_err", SW'(CTRCCU_Err), SW'(1));
        finish_cycle();
        step();
        step();
        settle();
        check("err_sticky", SW'(CTRCCU_Err), SW'(1));
        finish_cycle();

        // Config while busy is refused and leaves Err alone.
        ret_budget = 0;
        eng_left[0] = 1;
        step();
        cfg_vld_r = 1'b1;
        cfg_en_r  = 4'b0000;
        settle();
        check("cfg_busy_rdy", SW'(CTRCCU_CfgRdy), SW'(0));
        finish_cycle();
        cfg_vld_r = 1'b0;
        cfg_en_r  = 4'b1111;
        settle();
        check("cfg_busy_err", SW'(CTRCCU_Err), SW'(1));
        finish_cycle();
        ret_budget = -1;
        eng_left[1] = 1;
        drain(30);
        check("busy_mask_kept", SW'(eng_left[1]), SW'(0));

        // An accepted config clears Err.
        do_cfg(4'b0011, 1'b0);
        settle();
        check("cfg_clear_err", SW'(CTRCCU_Err), SW'(0));
        finish_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
